// File: rtl/ysyx_23060191_mc_ctrl.sv
// Multi-cycle instruction controller: sequences fetch, decode, execute,
// optional data-memory access and write-back, owns the PC and the retired
// instruction counter, and parks in HALT (ebreak) or ERR (timeout,
// misaligned target, load+store conflict) until reset.
//
// Handshake (imem and dmem alike): a request transfers on a rising edge where
// both req_valid and req_ready are high; req_valid is a pure function of the
// state and stays high, unchanged, until that edge. After the transfer the
// controller waits for a single-cycle resp_valid; a resp_valid seen in any
// other state is ignored.
module ysyx_23060191_mc_ctrl #(
  parameter int                XLEN     = 32,
  parameter logic [XLEN-1:0]   RESET_PC = 32'h8000_0000,
  parameter int                CNT_W    = 64,
  parameter int                TIMEOUT  = 255  // must be >= 1
) (
  input  logic              clk,
  input  logic              rstn,
  // instruction memory
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_addr,
  input  logic              imem_resp_valid,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       inst,
  // decoder flags
  input  logic              wr_en_rd,
  input  logic              is_load,
  input  logic              is_store,
  input  logic              ecall_en,
  input  logic              mret_en,
  input  logic              ebreak_en,
  // PC targets
  input  logic [XLEN-1:0]   next_pc,
  input  logic [XLEN-1:0]   mtvec,
  input  logic [XLEN-1:0]   mepc,
  // data memory
  output logic              dmem_req_valid,
  input  logic              dmem_req_ready,
  input  logic              dmem_resp_valid,
  // strobes and status
  output logic              gpr_we,
  output logic              csr_we,
  output logic [XLEN-1:0]   pc,
  output logic              retire,
  output logic [CNT_W-1:0]  minstret,
  output logic              halted,
  output logic              err,
  // debug view of the FSM state
  output logic [3:0]        dbg_state
);

  typedef enum logic [3:0] {
    S_RST        = 4'd0,
    S_FETCH_REQ  = 4'd1,
    S_FETCH_WAIT = 4'd2,
    S_DECODE     = 4'd3,
    S_EXEC       = 4'd4,
    S_MEM_REQ    = 4'd5,
    S_MEM_WAIT   = 4'd6,
    S_WB         = 4'd7,
    S_HALT       = 4'd8,
    S_ERR        = 4'd9
  } state_t;

  localparam int WCNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_t            state;
  state_t            state_next;
  logic [XLEN-1:0]   pc_q;
  logic [WCNT_W-1:0] wait_cnt;
  logic              lat_wr;
  logic              lat_load;
  logic              lat_store;
  logic              lat_ecall;
  logic              lat_mret;

  logic [XLEN-1:0]   target;
  logic              target_ok;
  logic              commit;
  logic              wait_expired;

  // PC target selection for WB: ecall beats mret beats the EXU target
  always_comb begin
    target = next_pc;
    if (lat_ecall) begin
      target = mtvec;
    end else if (lat_mret) begin
      target = mepc;
    end
  end

  assign target_ok    = (target[1:0] == 2'b00);
  assign commit       = (state == S_WB) && target_ok;
  // The wait counter holds the number of response-less cycles already spent;
  // the TIMEOUT-th such cycle gives up.
  assign wait_expired = (wait_cnt == WCNT_W'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= S_RST;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      S_RST:        state_next = S_FETCH_REQ;
      S_FETCH_REQ:  if (imem_req_ready) state_next = S_FETCH_WAIT;
      S_FETCH_WAIT: begin
        if (imem_resp_valid)   state_next = S_DECODE;
        else if (wait_expired) state_next = S_ERR;
      end
      S_DECODE:     state_next = ebreak_en ? S_HALT : S_EXEC;
      S_EXEC: begin
        if (lat_load && lat_store)      state_next = S_ERR;
        else if (lat_load || lat_store) state_next = S_MEM_REQ;
        else                            state_next = S_WB;
      end
      S_MEM_REQ:    if (dmem_req_ready) state_next = S_MEM_WAIT;
      S_MEM_WAIT: begin
        if (dmem_resp_valid)   state_next = S_WB;
        else if (wait_expired) state_next = S_ERR;
      end
      S_WB:         state_next = target_ok ? S_FETCH_REQ : S_ERR;
      S_HALT:       state_next = S_HALT;
      S_ERR:        state_next = S_ERR;
      default:      state_next = S_ERR;
    endcase
  end

  // Datapath registers: PC, instruction, decoder flags, counters
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pc_q      <= RESET_PC;
      inst      <= 32'h0;
      minstret  <= '0;
      wait_cnt  <= '0;
      lat_wr    <= 1'b0;
      lat_load  <= 1'b0;
      lat_store <= 1'b0;
      lat_ecall <= 1'b0;
      lat_mret  <= 1'b0;
    end else begin
      // Cleared while requesting so each wait starts from zero
      if (state == S_FETCH_REQ || state == S_MEM_REQ) begin
        wait_cnt <= '0;
      end else if (state == S_FETCH_WAIT || state == S_MEM_WAIT) begin
        wait_cnt <= wait_cnt + WCNT_W'(1);
      end
      if (state == S_FETCH_WAIT && imem_resp_valid) begin
        inst <= imem_rdata;
      end
      if (state == S_DECODE) begin
        lat_wr    <= wr_en_rd;
        lat_load  <= is_load;
        lat_store <= is_store;
        lat_ecall <= ecall_en;
        lat_mret  <= mret_en;
      end
      if (commit) begin
        pc_q     <= target;
        minstret <= minstret + CNT_W'(1);
      end
    end
  end

  // Outputs: requests are Moore; WB strobes only fire on a committing WB
  always_comb begin
    imem_req_valid = (state == S_FETCH_REQ);
    dmem_req_valid = (state == S_MEM_REQ);
    retire         = commit;
    gpr_we         = commit && lat_wr && !lat_store;
    csr_we         = commit && lat_ecall;
    halted         = (state == S_HALT);
    err            = (state == S_ERR);
  end

  assign pc        = pc_q;
  assign imem_addr = pc_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_ysyx_23060191_mc_ctrl.sv
// Directed bench for the multi-cycle controller: a table of instruction
// records (flags, targets, memory delays, expected outcome) driven through a
// cycle-level memory/decoder driver, plus hand-written sequences for fetch
// timeout, reset during a handshake and minstret wrap on a 4-bit counter.
module tb_ysyx_23060191_mc_ctrl;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        imem_req_ready, imem_resp_valid;
  logic [31:0] imem_rdata;
  logic        wr_en_rd, is_load, is_store, ecall_en, mret_en, ebreak_en;
  logic [31:0] next_pc, mtvec, mepc;
  logic        dmem_req_ready, dmem_resp_valid;

  logic        imem_req_valid, dmem_req_valid, gpr_we, csr_we, retire, halted, err;
  logic [31:0] imem_addr, inst, pc;
  logic [63:0] minstret;
  logic [3:0]  dbg_state;

  logic        imem_req_valid4, dmem_req_valid4, gpr_we4, csr_we4, retire4, halted4, err4;
  logic [31:0] imem_addr4, inst4, pc4;
  logic [3:0]  minstret4;
  logic [3:0]  dbg_state4;

  ysyx_23060191_mc_ctrl dut (
    .clk(clk), .rstn(rstn),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr), .imem_resp_valid(imem_resp_valid),
    .imem_rdata(imem_rdata), .inst(inst),
    .wr_en_rd(wr_en_rd), .is_load(is_load), .is_store(is_store),
    .ecall_en(ecall_en), .mret_en(mret_en), .ebreak_en(ebreak_en),
    .next_pc(next_pc), .mtvec(mtvec), .mepc(mepc),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_resp_valid(dmem_resp_valid),
    .gpr_we(gpr_we), .csr_we(csr_we), .pc(pc), .retire(retire),
    .minstret(minstret), .halted(halted), .err(err), .dbg_state(dbg_state)
  );

  // Same stimulus, 4-bit retire counter
  ysyx_23060191_mc_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rstn(rstn),
    .imem_req_valid(imem_req_valid4), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr4), .imem_resp_valid(imem_resp_valid),
    .imem_rdata(imem_rdata), .inst(inst4),
    .wr_en_rd(wr_en_rd), .is_load(is_load), .is_store(is_store),
    .ecall_en(ecall_en), .mret_en(mret_en), .ebreak_en(ebreak_en),
    .next_pc(next_pc), .mtvec(mtvec), .mepc(mepc),
    .dmem_req_valid(dmem_req_valid4), .dmem_req_ready(dmem_req_ready),
    .dmem_resp_valid(dmem_resp_valid),
    .gpr_we(gpr_we4), .csr_we(csr_we4), .pc(pc4), .retire(retire4),
    .minstret(minstret4), .halted(halted4), .err(err4), .dbg_state(dbg_state4)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int exp_ret  = 0;   // model of retired instructions since last reset

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst_before;
    logic [31:0] rdata;
    logic [5:0]  flags;      // {wr, ld, st, ecall, mret, ebreak}
    logic [31:0] npc;
    logic [31:0] tvec;
    logic [31:0] epc;
    int          rdy_dly;
    int          rsp_dly;
    int          kind;       // 0 retire, 1 err, 2 halt
    int          ev_cyc;     // cycle (FETCH_REQ = 1) of the event
    logic [31:0] exp_pc;
    int          exp_gpr;
    int          exp_csr;
  } vec_t;

  function automatic vec_t mk(logic rst, logic [31:0] rdata, logic [5:0] flags,
                              logic [31:0] npc, logic [31:0] tvec, logic [31:0] epc,
                              int rdy, int rsp, int kind, int cyc,
                              logic [31:0] epcv, int eg, int ec);
    vec_t v;
    v.rst_before = rst; v.rdata = rdata; v.flags = flags;
    v.npc = npc; v.tvec = tvec; v.epc = epc;
    v.rdy_dly = rdy; v.rsp_dly = rsp; v.kind = kind; v.ev_cyc = cyc;
    v.exp_pc = epcv; v.exp_gpr = eg; v.exp_csr = ec;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_rdata = 32'h0;
    {wr_en_rd, is_load, is_store, ecall_en, mret_en, ebreak_en} = 6'b0;
    next_pc = 32'h0; mtvec = 32'h0; mepc = 32'h0;
    dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0;
  endtask

  // Leaves the DUT in FETCH_REQ, sampled 1 time unit after the edge
  task automatic reset_dut();
    rstn = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc", pc, RST_PC);
    check("rst_imem_addr", imem_addr, RST_PC);
    check("rst_inst", inst, 32'h0);
    check("rst_minstret", minstret, 64'h0);
    check("rst_minstret4", minstret4, 4'h0);
    check("rst_outs", {imem_req_valid, dmem_req_valid, gpr_we, csr_we, retire, halted, err}, 7'b0);
    check("rst_state", dbg_state, 4'd0);
    rstn = 1'b1;
    exp_ret = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int c, ev_cyc, ev_kind, gpr_cnt, csr_cnt, ret_cnt, dreq, wcnt;
    logic hs, hs_now;
    logic [31:0] ev_inst;
    if (v.rst_before) reset_dut();
    c = 1; ev_kind = -1; ev_cyc = 0; gpr_cnt = 0; csr_cnt = 0; ret_cnt = 0;
    dreq = 0; wcnt = 0; hs = 1'b0; ev_inst = 32'h0;
    while (c <= 60 && ev_kind < 0) begin
      imem_req_ready  = 1'b1;
      imem_resp_valid = 1'b1;
      imem_rdata      = (c == 2) ? v.rdata : 32'hdead_beef;
      // flags are only meaningful in DECODE (cycle 3); inverted elsewhere
      {wr_en_rd, is_load, is_store, ecall_en, mret_en, ebreak_en} = (c == 3) ? v.flags : ~v.flags;
      next_pc = v.npc; mtvec = v.tvec; mepc = v.epc;
      dmem_req_ready  = (dreq >= v.rdy_dly);
      dmem_resp_valid = hs && (wcnt >= v.rsp_dly);
      #1;
      if (gpr_we) gpr_cnt++;
      if (csr_we) csr_cnt++;
      if (retire) ret_cnt++;
      if (retire)      ev_kind = 0;
      else if (err)    ev_kind = 1;
      else if (halted) ev_kind = 2;
      if (ev_kind >= 0) begin ev_cyc = c; ev_inst = inst; end
      hs_now = dmem_req_valid && dmem_req_ready;
      if (dmem_req_valid) dreq++;
      if (hs) wcnt++;
      if (hs_now) begin hs = 1'b1; wcnt = 0; end
      @(posedge clk);
      #1;
      c++;
    end
    if (v.kind == 0) exp_ret++;
    check({tag, "_kind"}, ev_kind, v.kind);
    check({tag, "_cycle"}, ev_cyc, v.ev_cyc);
    check({tag, "_pc"}, pc, v.exp_pc);
    check({tag, "_imem_addr"}, imem_addr, v.exp_pc);
    check({tag, "_inst"}, ev_inst, v.rdata);
    check({tag, "_minstret"}, minstret, exp_ret);
    check({tag, "_minstret4"}, minstret4, exp_ret % 16);
    check({tag, "_gpr_we_cycles"}, gpr_cnt, v.exp_gpr);
    check({tag, "_csr_we_cycles"}, csr_cnt, v.exp_csr);
    check({tag, "_retire_cycles"}, ret_cnt, (v.kind == 0) ? 1 : 0);
    check({tag, "_dreq_cycles"}, dreq, (v.flags[4] ^ v.flags[3]) ? v.rdy_dly + 1 : 0);
    if (v.kind == 0) begin
      check({tag, "_next_fetch"}, imem_req_valid, 1'b1);
    end else begin
      // absorbing: no requests, no strobes, status held
      for (int k = 0; k < 3; k++) begin
        imem_req_ready = 1'b1; imem_resp_valid = 1'b1;
        dmem_req_ready = 1'b1; dmem_resp_valid = 1'b1;
        #1;
        check({tag, "_park_outs"},
              {imem_req_valid, dmem_req_valid, gpr_we, csr_we, retire, halted, err},
              {5'b0, v.kind == 2, v.kind == 1});
        @(posedge clk);
        #1;
      end
      check({tag, "_park_minstret"}, minstret, exp_ret);
    end
  endtask

  // ---------------- test ----------------
  vec_t vecs[12];

  localparam logic [31:0] I_ADDI = 32'h0010_0093;
  localparam logic [31:0] I_LW   = 32'h0000_a103;
  localparam logic [31:0] I_SW   = 32'h0020_a023;
  localparam logic [31:0] I_ECAL = 32'h0000_0073;
  localparam logic [31:0] I_MRET = 32'h3020_0073;
  localparam logic [31:0] I_EBRK = 32'h0010_0073;

  initial begin
    // flags: {wr, ld, st, ecall, mret, ebreak}
    vecs[0]  = mk(1, I_ADDI, 6'b100000, 32'h8000_0004, 32'h8000_0100, 32'h8000_0040, 0, 0, 0, 5,  32'h8000_0004, 1, 0);
    vecs[1]  = mk(0, I_LW,   6'b110000, 32'h8000_0008, 32'h8000_0100, 32'h8000_0040, 2, 3, 0, 12, 32'h8000_0008, 1, 0);
    vecs[2]  = mk(0, I_SW,   6'b101000, 32'h8000_000C, 32'h8000_0100, 32'h8000_0040, 0, 0, 0, 7,  32'h8000_000C, 0, 0);
    vecs[3]  = mk(0, I_ECAL, 6'b000110, 32'h8000_0010, 32'h8000_0100, 32'h8000_0040, 0, 0, 0, 5,  32'h8000_0100, 0, 1);
    vecs[4]  = mk(0, I_MRET, 6'b100010, 32'h8000_0104, 32'h8000_0100, 32'h8000_0040, 0, 0, 0, 5,  32'h8000_0040, 1, 0);
    vecs[5]  = mk(0, I_LW,   6'b110000, 32'h8000_0044, 32'h8000_0100, 32'h8000_0040, 0, 0, 0, 7,  32'h8000_0044, 1, 0);
    vecs[6]  = mk(0, I_SW,   6'b001000, 32'h8000_0048, 32'h8000_0100, 32'h8000_0040, 1, 1, 0, 9,  32'h8000_0048, 0, 0);
    vecs[7]  = mk(0, I_ADDI, 6'b100000, 32'h8000_0002, 32'h8000_0100, 32'h8000_0040, 0, 0, 1, 6,  32'h8000_0048, 0, 0);
    vecs[8]  = mk(1, I_EBRK, 6'b000001, 32'h8000_0004, 32'h8000_0100, 32'h8000_0040, 0, 0, 2, 4,  32'h8000_0000, 0, 0);
    vecs[9]  = mk(1, I_ADDI, 6'b100000, 32'h8000_0004, 32'h8000_0100, 32'h8000_0040, 0, 0, 0, 5,  32'h8000_0004, 1, 0);
    vecs[10] = mk(0, I_LW,   6'b111000, 32'h8000_0008, 32'h8000_0100, 32'h8000_0040, 0, 0, 1, 5,  32'h8000_0004, 0, 0);
    vecs[11] = mk(1, I_ECAL, 6'b000100, 32'h8000_0004, 32'h8000_0101, 32'h8000_0040, 0, 0, 1, 6,  32'h8000_0000, 0, 0);

    idle_inputs();
    for (int i = 0; i < 12; i++) begin
      run_vec(vecs[i], $sformatf("v%0d", i));
    end

    // Fetch response never arrives: TIMEOUT (255) wait cycles, ERR in cycle 257
    begin
      int first_err;
      reset_dut();
      first_err = 0;
      for (int c = 1; c <= 300 && first_err == 0; c++) begin
        imem_req_ready = 1'b1; imem_resp_valid = 1'b0;
        #1;
        if (err) first_err = c;
        @(posedge clk);
        #1;
      end
      check("timeout_err_cycle", first_err, 257);
      check("timeout_minstret", minstret, 64'h0);
      check("timeout_no_req", {imem_req_valid, dmem_req_valid}, 2'b00);
    end

    // Reset while waiting for a fetch response; the late response is dropped
    begin
      reset_dut();
      imem_req_ready = 1'b1; imem_resp_valid = 1'b0;
      @(posedge clk); #1;                       // now FETCH_WAIT
      rstn = 1'b0; imem_resp_valid = 1'b1; imem_rdata = 32'h1234_5678;
      @(posedge clk); #1;                       // RST
      check("midrst_inst", inst, 32'h0);
      check("midrst_req", imem_req_valid, 1'b0);
      rstn = 1'b1; imem_req_ready = 1'b0;
      @(posedge clk); #1;                       // FETCH_REQ, ready held low
      for (int k = 0; k < 3; k++) begin
        check("midrst_fetch_held", imem_req_valid, 1'b1);
        check("midrst_inst_held", inst, 32'h0);
        @(posedge clk); #1;
      end
      check("midrst_pc", pc, RST_PC);
    end

    // 16 retires: the 4-bit counter wraps back to zero
    begin
      logic [31:0] p;
      reset_dut();
      p = RST_PC;
      for (int n = 0; n < 16; n++) begin
        run_vec(mk(0, I_ADDI, 6'b100000, p + 32'h4, 32'h8000_0100, 32'h8000_0040,
                   0, 0, 0, 5, p + 32'h4, 1, 0), $sformatf("wrap%0d", n));
        p = p + 32'h4;
      end
      check("wrap4_zero", minstret4, 4'h0);
      check("wrap64_count", minstret, 64'd16);
      check("wrap4_pc", pc4, RST_PC + 32'd64);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ysyx_23060191_mc_ctrl.md
YSYX_23060191_MC_CTRL -- requirements
Module: ysyx_23060191_mc_ctrl

Interface
REQ-001 Parameters: XLEN, default 32, datapath/PC width; RESET_PC, default 32'h8000_0000, PC after reset; CNT_W, default 64, retire-counter width; TIMEOUT, default 255, max wait cycles per memory response.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rstn  input  1  synchronous, active-low reset.
REQ-004 imem_req_valid  output  1  fetch request; imem_req_ready  input  1  fetch request accepted.
REQ-005 imem_addr  output  XLEN  fetch address, equals pc.
REQ-006 imem_resp_valid  input  1; imem_rdata  input  32  fetched instruction.
REQ-007 inst  output  32  latched instruction, stable from DECODE through WB.
REQ-008 wr_en_rd, is_load, is_store, ecall_en, mret_en, ebreak_en  input  1 each  decoder flags, sampled in DECODE.
REQ-009 next_pc  input  XLEN  sequential/branch/jump target from EXU, sampled in WB; mtvec, mepc  input  XLEN  trap/return targets.
REQ-010 dmem_req_valid  output  1; dmem_req_ready  input  1; dmem_resp_valid  input  1  data-memory handshake.
REQ-011 gpr_we  output  1  GPR write strobe; csr_we  output  1  trap CSR write strobe.
REQ-012 pc  output  XLEN; retire  output  1  one-cycle pulse per committed instruction; minstret  output  CNT_W  retired count.
REQ-013 halted  output  1  ebreak reached; err  output  1  timeout or misaligned target.

Function
REQ-014 States: RST, FETCH_REQ, FETCH_WAIT, DECODE, EXEC, MEM_REQ, MEM_WAIT, WB, HALT, ERR; one-hot or binary is implementer's choice.
REQ-015 RST -> FETCH_REQ unconditionally after one cycle; no request asserted in RST.
REQ-016 FETCH_REQ: imem_req_valid=1, held until imem_req_ready=1; then -> FETCH_WAIT.
REQ-017 FETCH_WAIT: on imem_resp_valid=1 latch imem_rdata into inst, -> DECODE; responses outside FETCH_WAIT/MEM_WAIT ignored.
REQ-018 DECODE (1 cycle): latch flags; ebreak_en=1 -> HALT, else -> EXEC.
REQ-019 EXEC (1 cycle): is_load|is_store -> MEM_REQ, else -> WB; is_load and is_store both 1 -> ERR.
REQ-020 MEM_REQ/MEM_WAIT: same handshake rules as fetch using dmem_*; -> WB on dmem_resp_valid.
REQ-021 WB (1 cycle): gpr_we=latched wr_en_rd & ~is_store; retire=1; minstret+1, wraps to 0 at 2^CNT_W.
REQ-022 WB pc update priority: ecall_en -> mtvec with csr_we=1; else mret_en -> mepc; else next_pc; then -> FETCH_REQ.
REQ-023 Selected target with bits[1:0]!=0 -> ERR instead of update; no retire, pc unchanged.
REQ-024 Wait counter clears on entering each WAIT state, increments per cycle; reaching TIMEOUT without response -> ERR.
REQ-025 HALT and ERR absorbing until reset; all request/strobe outputs 0; halted=1 in HALT only, err=1 in ERR only.
REQ-026 Request outputs driven from state only (Moore); gpr_we, csr_we, retire asserted only in WB.
REQ-027 Latency without waits: non-memory instruction 5 cycles FETCH_REQ-to-retire with ready/resp same-cycle; memory instruction 7.

Reset
REQ-028 rstn=0 at any edge, any state: next state RST, pc=RESET_PC, inst=0, minstret=0, wait counter=0, all outputs 0 except pc/imem_addr.
REQ-029 Reset mid-handshake abandons the transaction; a response arriving afterward is discarded.

Verification
REQ-030 Reset, imem ready/resp immediate, inst=ADDI, next_pc=RESET_PC+4 -> retire at cycle 5, pc=0x8000_0004, minstret=1, gpr_we pulse 1 cycle.
REQ-031 Load with dmem_resp delayed 3 cycles -> dmem_req_valid held until ready, retire 3 cycles late, gpr_we=1; store -> gpr_we=0.
REQ-032 ecall_en=1, mret_en=1, mtvec=0x8000_0100 -> pc=0x8000_0100, csr_we=1; mret only, mepc=0x8000_0040 -> pc=0x8000_0040.
REQ-033 imem_resp_valid never asserted -> err=1 after TIMEOUT wait cycles; next_pc=0x8000_0002 -> err=1, minstret unchanged.
REQ-034 ebreak_en in DECODE -> halted=1 next cycle, no further requests, minstret unchanged; rstn=0 -> restart at RESET_PC.
REQ-035 minstret preloaded near wrap via CNT_W=4 build, 16 retires -> wraps to 0.
